// File: rtl/x25519_pkg.sv
// Shared GF(2^255-19) constants and the reducer state encoding.
package x25519_pkg;

  localparam int FIELD_BITS = 255;
  localparam int FOLD_K     = 19;
  localparam logic [254:0] P25519 = {{250{1'b1}}, 5'b01101};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    FLUSH = 3'd2,
    FOLD  = 3'd3,
    CANON = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/x25519_streaming_reducer_adder.sv
// x25519_limb_serial_adder: one limb per cycle plus a wide addend, carry kept in a register.
module x25519_limb_serial_adder #(
  parameter int LIMB_BITS  = 8,
  parameter int CARRY_BITS = 38
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [LIMB_BITS-1:0]  a,
  input  logic [CARRY_BITS-1:0] b,
  output logic [LIMB_BITS-1:0]  sum,
  output logic [CARRY_BITS-1:0] cout
);

  logic [CARRY_BITS-1:0] carry;
  logic [CARRY_BITS:0]   total;

  always_comb begin
    total = {1'b0, b} + {{(CARRY_BITS + 1 - LIMB_BITS){1'b0}}, a} + {1'b0, carry};
    sum   = total[LIMB_BITS-1:0];
    cout  = CARRY_BITS'(total >> LIMB_BITS);
  end

  // clr wins over en so a pass can end and restart on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry <= '0;
    end else if (clr) begin
      carry <= '0;
    end else if (en) begin
      carry <= cout;
    end
  end

endmodule

// File: rtl/x25519_streaming_reducer.sv
// Column-stream carry ripple and x19 fold for GF(2^255-19).
// X25519_CANONICAL_EN adds a final CANON pass giving a fully reduced result in [0, p).
module x25519_streaming_reducer #(
  parameter int LIMB_BITS  = 8,
  parameter int NUM_LIMBS  = 32,
  parameter int IN_WIDTH   = 32,
  parameter int FIELD_BITS = x25519_pkg::FIELD_BITS,
  parameter int FOLD_K     = x25519_pkg::FOLD_K,
  localparam int OUT_WIDTH = LIMB_BITS * NUM_LIMBS + LIMB_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 din_valid,
  input  logic [IN_WIDTH-1:0]  din,
  output logic                 busy,
  output logic                 overrun,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out
);

  import x25519_pkg::*;

  localparam int ACC_W     = IN_WIDTH + 1;
  localparam int CW        = IN_WIDTH + 1 + $clog2(FOLD_K + 1);
  localparam int CNT_W     = $clog2(NUM_LIMBS);
  // bit position of the fold point inside the most significant limb
  localparam int TOP_SHIFT = FIELD_BITS - LIMB_BITS * (NUM_LIMBS - 1);
  localparam logic [CNT_W-1:0]     LAST     = CNT_W'(NUM_LIMBS - 1);
  localparam logic [LIMB_BITS-1:0] TOP_MASK = LIMB_BITS'((64'd1 << TOP_SHIFT) - 64'd1);
  localparam logic [CW-1:0]        K_OP     = CW'(FOLD_K);
`ifdef X25519_CANONICAL_EN
  localparam state_t AFTER_FOLD = CANON;
`else
  localparam state_t AFTER_FOLD = DONE;
`endif

  if (IN_WIDTH <= LIMB_BITS) begin : g_chk_in
    $fatal(1, "IN_WIDTH must exceed LIMB_BITS");
  end
  if (FIELD_BITS >= LIMB_BITS * NUM_LIMBS) begin : g_chk_field
    $fatal(1, "FIELD_BITS must be below LIMB_BITS*NUM_LIMBS");
  end
  if (TOP_SHIFT < 0) begin : g_chk_top
    $fatal(1, "FIELD_BITS must fall inside the top limb");
  end

  state_t               state, state_nx, cur;
  logic [CNT_W-1:0]     cnt, cnt_nx, ccur;
  logic [ACC_W-1:0]     acc, acc_nx, acc_src;
  logic [CW-1:0]        fold_carry, fold_carry_nx, ov;
  logic                 pass, pass_nx;
  logic                 busy_nx, overrun_nx, out_valid_nx, out_we;
  logic [LIMB_BITS-1:0] limb [NUM_LIMBS];
  logic                 limb_we;
  logic [CNT_W-1:0]     limb_idx;
  logic [LIMB_BITS-1:0] limb_wd;
  logic                 add_clr, add_en;
  logic [LIMB_BITS-1:0] add_a, add_sum;
  logic [CW-1:0]        add_b, add_cout;
  logic [OUT_WIDTH-1:0] result;
`ifdef X25519_CANONICAL_EN
  logic [LIMB_BITS-1:0] t_limb [NUM_LIMBS];
  logic                 t_we, canon_sel, canon_sel_nx;
`endif

  assign add_a = limb[cnt];

  x25519_limb_serial_adder #(
    .LIMB_BITS (LIMB_BITS),
    .CARRY_BITS(CW)
  ) u_adder (
    .clk (clk),
    .rst (rst),
    .clr (add_clr),
    .en  (add_en),
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum),
    .cout(add_cout)
  );

  // start behaves as if the cycle began in a cleared IDLE, so a coincident beat becomes beat 0
  always_comb begin
    cur           = start ? IDLE : state;
    ccur          = start ? '0 : cnt;
    acc_src       = start ? '0 : acc;
    state_nx      = cur;
    cnt_nx        = ccur;
    acc_nx        = acc_src;
    fold_carry_nx = fold_carry;
    pass_nx       = start ? 1'b0 : pass;
    busy_nx       = start ? 1'b0 : busy;
    overrun_nx    = start ? 1'b0 : overrun;
    out_valid_nx  = 1'b0;
    out_we        = 1'b0;
    limb_we       = 1'b0;
    limb_idx      = ccur;
    limb_wd       = add_sum;
    add_en        = 1'b0;
    add_clr       = start;
    add_b         = '0;
    ov            = '0;
`ifdef X25519_CANONICAL_EN
    t_we          = 1'b0;
    canon_sel_nx  = canon_sel;
`endif
    case (cur)
      IDLE, ACCUM: begin
        if (din_valid) begin
          acc_nx   = (acc_src >> LIMB_BITS) + ACC_W'(din);
          limb_we  = (ccur != '0);
          limb_idx = ccur - CNT_W'(1);
          limb_wd  = acc_src[LIMB_BITS-1:0];
          busy_nx  = 1'b1;
          if (ccur == LAST) begin
            state_nx = FLUSH;
            cnt_nx   = '0;
          end else begin
            state_nx = ACCUM;
            cnt_nx   = ccur + CNT_W'(1);
          end
        end else begin
          state_nx = cur;
        end
      end
      FLUSH: begin
        limb_we       = 1'b1;
        limb_idx      = LAST;
        limb_wd       = acc_src[LIMB_BITS-1:0] & TOP_MASK;
        fold_carry_nx = CW'(acc_src >> TOP_SHIFT) * K_OP;
        acc_nx        = '0;
        cnt_nx        = '0;
        pass_nx       = 1'b0;
        add_clr       = 1'b1;
        state_nx      = FOLD;
        overrun_nx    = overrun | din_valid;
      end
      FOLD: begin
        add_en     = 1'b1;
        add_b      = (ccur == '0) ? fold_carry : '0;
        limb_we    = 1'b1;
        overrun_nx = overrun | din_valid;
        if (ccur == LAST) begin
          ov      = CW'(add_sum >> TOP_SHIFT) | (add_cout << (LIMB_BITS - TOP_SHIFT));
          limb_wd = add_sum & TOP_MASK;
          add_clr = 1'b1;
          cnt_nx  = '0;
          // a second pass only ever sees a tiny overflow, so it cannot overflow again
          if ((ov != '0) && (pass == 1'b0)) begin
            fold_carry_nx = ov * K_OP;
            pass_nx       = 1'b1;
            state_nx      = FOLD;
          end else begin
            state_nx = AFTER_FOLD;
          end
        end else begin
          cnt_nx = ccur + CNT_W'(1);
        end
      end
`ifdef X25519_CANONICAL_EN
      CANON: begin
        add_en     = 1'b1;
        add_b      = (ccur == '0) ? K_OP : '0;
        t_we       = 1'b1;
        overrun_nx = overrun | din_valid;
        if (ccur == LAST) begin
          canon_sel_nx = add_sum[TOP_SHIFT];
          add_clr      = 1'b1;
          cnt_nx       = '0;
          state_nx     = DONE;
        end else begin
          cnt_nx = ccur + CNT_W'(1);
        end
      end
`endif
      DONE: begin
        out_we       = 1'b1;
        out_valid_nx = 1'b1;
        busy_nx      = 1'b0;
        state_nx     = IDLE;
        overrun_nx   = overrun | din_valid;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    result = '0;
    for (int k = 0; k < NUM_LIMBS; k++) begin
`ifdef X25519_CANONICAL_EN
      result[k*LIMB_BITS +: LIMB_BITS] = canon_sel ? t_limb[k] : limb[k];
`else
      result[k*LIMB_BITS +: LIMB_BITS] = limb[k];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      fold_carry <= '0;
      pass       <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      acc        <= acc_nx;
      fold_carry <= fold_carry_nx;
      pass       <= pass_nx;
      busy       <= busy_nx;
      overrun    <= overrun_nx;
      out_valid  <= out_valid_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_LIMBS; k++) limb[k] <= '0;
    end else if (limb_we) begin
      limb[limb_idx] <= limb_wd;
    end
  end

`ifdef X25519_CANONICAL_EN
  // t = v + FOLD_K kept apart from v until the final carry picks one of them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_LIMBS; k++) t_limb[k] <= '0;
      canon_sel <= 1'b0;
    end else begin
      if (t_we) t_limb[cnt] <= (cnt == LAST) ? (add_sum & TOP_MASK) : add_sum;
      canon_sel <= canon_sel_nx;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
    end else if (out_we) begin
      out <= result;
    end
  end

endmodule

// File: tb/tb_x25519_streaming_reducer.sv
// Directed and random streams against a modular golden model held in a scoreboard queue.
module tb_x25519_streaming_reducer;

  localparam int LB = 8;
  localparam int NL = 32;
  localparam int IW = 32;
  localparam int OW = LB * NL + LB;
`ifdef X25519_CANONICAL_EN
  localparam int EXTRA = NL;
`else
  localparam int EXTRA = 0;
`endif
  // clock edges from the edge sampling the last beat to the negedge showing out_valid
  localparam int LAT1 = 2 + NL + 1 - 1 + EXTRA;

  logic          clk = 1'b0;
  logic          rst, start, din_valid;
  logic [IW-1:0] din;
  logic          busy, overrun, out_valid;
  logic [OW-1:0] out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int last_cyc = 0;
  int p0;
  logic [299:0]  P;
  logic [299:0]  exp_q[$];
  logic [IW-1:0] cols [NL];
  logic [OW-1:0] held;

  x25519_streaming_reducer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .din_valid(din_valid),
    .din      (din),
    .busy     (busy),
    .overrun  (overrun),
    .out_valid(out_valid),
    .out      (out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (out_valid === 1'b1) pulses <= pulses + 1;

  task automatic check_val(input string tag, input logic [299:0] got, input logic [299:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic beat(input logic [IW-1:0] d, input bit st);
    start = st;
    din = d;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    start = 1'b0;
    din = '0;
  endtask

  task automatic send_stream(input int maxgap, input bit st0, input bit push);
    logic [299:0] v;
    v = '0;
    for (int i = 0; i < NL; i++) begin
      if (maxgap > 0 && i > 0) repeat ($urandom_range(maxgap, 1)) begin @(posedge clk); #1; end
      beat(cols[i], (i == 0) ? st0 : 1'b0);
      v = v + (300'(cols[i]) << (LB * i));
    end
    last_cyc = cyc;
    if (push) exp_q.push_back(v % P);
  endtask

  task automatic expect_result(input string tag, input int lat_want);
    bit seen;
    int lat;
    logic [299:0] want;
    seen = 1'b0;
    lat = 0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        lat = cyc - last_cyc;
      end
    end
    checks++;
    assert (seen) else begin
      errors++;
      $error("FAIL %s_timeout: observed out_valid=0 expected 1", tag);
    end
    if (seen) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL %s_queue: observed empty scoreboard expected an entry", tag);
      end
      want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
`ifdef X25519_CANONICAL_EN
      check_val({tag, "_out"}, 300'(out), want);
`else
      check_val({tag, "_mod"}, 300'(out) % P, want);
      check_val({tag, "_hi"}, 300'(out >> 255), 300'd0);
`endif
      check_val({tag, "_busy"}, 300'(busy), 300'd0);
      if (lat_want >= 0) check_val({tag, "_lat"}, 300'(lat), 300'(lat_want));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    P = (300'd1 << 255) - 300'd19;
    rst = 1'b1;
    start = 1'b0;
    din_valid = 1'b0;
    din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", 300'(busy), 300'd0);
    check_val("rst_overrun", 300'(overrun), 300'd0);
    check_val("rst_valid", 300'(out_valid), 300'd0);
    check_val("rst_out", 300'(out), 300'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: single small column, single pass, latency and busy
    for (int i = 0; i < NL; i++) cols[i] = '0;
    cols[0] = 32'd5;
    send_stream(0, 1'b0, 1'b1);
    check_val("t1_busy_run", 300'(busy), 300'd1);
    expect_result("t1", LAT1);
    check_val("t1_exact", 300'(out), 300'd5);

    // 2: 2^255 folds to 19
    for (int i = 0; i < NL; i++) cols[i] = '0;
    cols[31] = 32'h80;
    send_stream(0, 1'b0, 1'b1);
    expect_result("t2", -1);
    check_val("t2_exact", 300'(out), 300'd19);
`ifdef X25519_CANONICAL_EN
    cols[0] = 32'hED;
    for (int i = 1; i < NL - 1; i++) cols[i] = 32'hFF;
    cols[31] = 32'h7F;
    send_stream(0, 1'b0, 1'b1);
    expect_result("t2_p", -1);
    check_val("t2_p_exact", 300'(out), 300'd0);
    cols[0] = 32'hEE;
    send_stream(0, 1'b0, 1'b1);
    expect_result("t2_p1", -1);
    check_val("t2_p1_exact", 300'(out), 300'd1);
`endif

    // 3: all-ones columns
    for (int i = 0; i < NL; i++) cols[i] = 32'hFFFF_FFFF;
    send_stream(0, 1'b0, 1'b1);
    expect_result("t3", -1);

    // 4: same random stream gapless then with 1-3 cycle gaps, plus a surplus beat
    for (int i = 0; i < NL; i++) cols[i] = $urandom;
    send_stream(0, 1'b0, 1'b1);
    expect_result("t4_nogap", -1);
    check_val("t4_no_overrun", 300'(overrun), 300'd0);
    send_stream(3, 1'b0, 1'b1);
    beat(32'hDEAD_BEEF, 1'b0);
    expect_result("t4_gap", -1);
    check_val("t4_overrun", 300'(overrun), 300'd1);

    // 5: abort at beat 17, then a start coinciding with beat 0 of a fresh stream
    held = out;
    for (int i = 0; i < NL; i++) cols[i] = $urandom;
    for (int i = 0; i < 17; i++) beat(cols[i], 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("t5_abort_busy", 300'(busy), 300'd0);
    check_val("t5_abort_overrun", 300'(overrun), 300'd0);
    check_val("t5_abort_out", 300'(out), 300'(held));
    p0 = pulses;
    for (int i = 0; i < 5; i++) beat($urandom, 1'b0);
    for (int i = 0; i < NL; i++) cols[i] = $urandom;
    send_stream(0, 1'b1, 1'b1);
    expect_result("t5", -1);
    repeat (5) @(posedge clk);
    #1;
    check_val("t5_pulses", 300'(pulses - p0), 300'd1);

    // 6: reset during FOLD
    for (int i = 0; i < NL; i++) cols[i] = $urandom;
    send_stream(0, 1'b0, 1'b0);
    beat(32'h1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_val("t6_busy", 300'(busy), 300'd0);
    check_val("t6_overrun", 300'(overrun), 300'd0);
    check_val("t6_valid", 300'(out_valid), 300'd0);
    check_val("t6_out", 300'(out), 300'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    p0 = pulses;
    repeat (120) @(posedge clk);
    #1;
    check_val("t6_no_pulse", 300'(pulses - p0), 300'd0);
    send_stream(0, 1'b0, 1'b1);
    expect_result("t6_after", -1);

    // random streams, alternating gapless and gapped
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < NL; i++) cols[i] = $urandom;
      if (r % 5 == 0) for (int i = 0; i < NL; i++) cols[i] = 32'hFFFF_FFFF - (cols[i] & 32'hF);
      send_stream((r % 2) * 3, 1'b0, 1'b1);
      expect_result("rnd", -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
